// File: rtl/board_if.sv
// board_if: renderer/game-logic bundle for board_ctrl (requester writes, line-clear control, board readout).
interface board_if #(
  parameter int COLS   = 10,
  parameter int ROWS   = 20,
  parameter int CELL_W = 4
);
  logic                          i_sync_va;
  logic                          i_req0_valid;
  logic [4:0]                    i_req0_row;
  logic [3:0]                    i_req0_col;
  logic [CELL_W-1:0]             i_req0_cell;
  logic                          o_req0_ready;
  logic                          i_req1_valid;
  logic [4:0]                    i_req1_row;
  logic [3:0]                    i_req1_col;
  logic [CELL_W-1:0]             i_req1_cell;
  logic                          o_req1_ready;
  logic                          i_clr_start;
  logic                          o_clr_busy;
  logic                          o_clr_done;
  logic [4:0]                    o_clr_lines;
  logic                          o_wr_err;
  logic [4:0]                    i_rd_row;
  logic [3:0]                    i_rd_col;
  logic [CELL_W-1:0]             o_rd_cell;
  logic [COLS*ROWS*CELL_W-1:0]   o_board;
  modport master (
    output i_sync_va, i_req0_valid, i_req0_row, i_req0_col, i_req0_cell,
    output i_req1_valid, i_req1_row, i_req1_col, i_req1_cell,
    output i_clr_start, i_rd_row, i_rd_col,
    input  o_req0_ready, o_req1_ready, o_clr_busy, o_clr_done, o_clr_lines,
    input  o_wr_err, o_rd_cell, o_board
  );
  modport slave (
    input  i_sync_va, i_req0_valid, i_req0_row, i_req0_col, i_req0_cell,
    input  i_req1_valid, i_req1_row, i_req1_col, i_req1_cell,
    input  i_clr_start, i_rd_row, i_rd_col,
    output o_req0_ready, o_req1_ready, o_clr_busy, o_clr_done, o_clr_lines,
    output o_wr_err, o_rd_cell, o_board
  );
endinterface

// File: rtl/board_ctrl.sv
// board_ctrl: play-field cell store with blanking-gated writes and a line-clear engine.
// Define BOARD_CTRL_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module board_ctrl #(
  parameter int COLS   = 10,
  parameter int ROWS   = 20,
  parameter int CELL_W = 4
) (
  input logic   clk,
  input logic   rst_n,
  board_if.slave bus
);
  localparam logic [4:0] ROWS_L = 5'(ROWS);
  localparam logic [3:0] COLS_L = 4'(COLS);
  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;
  state_t            state;
  logic [CELL_W-1:0] cells [ROWS][COLS];
  logic [4:0]        r;
  logic [4:0]        lines;
  logic              pending;
  logic              busy;
  logic              done;
  logic              wr_err;
  logic              ptr;
  logic              open;
  logic              start_req;
  logic              g0;
  logic              g1;
  logic [4:0]        w_row;
  logic [3:0]        w_col;
  logic [CELL_W-1:0] w_cell;
  logic              in_range;
  logic              row_full;
`ifndef BOARD_CTRL_RR_EN
  assign ptr = 1'b0;
`endif
  assign start_req = bus.i_clr_start | pending;
  // Grants only while idle, in blanking, out of reset, and with no scan about to start.
  assign open      = rst_n && state == IDLE && !bus.i_sync_va && !start_req;
  assign g0        = open && bus.i_req0_valid && (!bus.i_req1_valid || !ptr);
  assign g1        = open && bus.i_req1_valid && (!bus.i_req0_valid || ptr);
  assign w_row     = g1 ? bus.i_req1_row  : bus.i_req0_row;
  assign w_col     = g1 ? bus.i_req1_col  : bus.i_req0_col;
  assign w_cell    = g1 ? bus.i_req1_cell : bus.i_req0_cell;
  assign in_range  = w_row < ROWS_L && w_col < COLS_L;
  assign bus.o_req0_ready = g0;
  assign bus.o_req1_ready = g1;
  assign bus.o_clr_busy   = busy;
  assign bus.o_clr_done   = done;
  assign bus.o_clr_lines  = lines;
  assign bus.o_wr_err     = wr_err;
  assign bus.o_rd_cell    = (bus.i_rd_row < ROWS_L && bus.i_rd_col < COLS_L) ?
                            cells[bus.i_rd_row][bus.i_rd_col] : '0;
  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++)
      if (cells[r][c] == '0) row_full = 1'b0;
  end
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      assign bus.o_board[(i*COLS+j)*CELL_W +: CELL_W] = cells[i][j];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      r       <= '0;
      lines   <= '0;
      pending <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_err  <= 1'b0;
`ifdef BOARD_CTRL_RR_EN
      ptr     <= 1'b0;
`endif
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          cells[i][j] <= '0;
    end else begin
      done   <= 1'b0;
      wr_err <= 1'b0;
      if (state == IDLE) begin
        if (bus.i_sync_va) pending <= start_req;
        else if (start_req) begin
          state   <= SCAN;
          r       <= 5'(ROWS-1);
          lines   <= '0;
          busy    <= 1'b1;
          pending <= 1'b0;
        end else if (g0 | g1) begin
          if (in_range) cells[w_row][w_col] <= w_cell;
          else wr_err <= 1'b1;
`ifdef BOARD_CTRL_RR_EN
          ptr <= g0;
`endif
        end
      end else if (!bus.i_sync_va) begin
        case (state)
          SCAN: begin
            if (row_full) state <= SHIFT;
            else if (r == 5'd0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else r <= r - 5'd1;
          end
          SHIFT: begin
            // Everything at or above r drops one row; row 0 refills empty.
            for (int i = 1; i < ROWS; i++)
              if (5'(i) <= r) cells[i] <= cells[i-1];
            for (int j = 0; j < COLS; j++)
              cells[0][j] <= '0;
            lines <= (lines == 5'd31) ? lines : lines + 5'd1;
            state <= SCAN;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_board_ctrl.sv
// tb_board_ctrl: scoreboard bench for board_ctrl; expected grants, write errors and scan
// completions are queued by the stimulus and popped by a negedge monitor.
module tb_board_ctrl;
  localparam int COLS = 10, ROWS = 20, CELL_W = 4, BW = COLS*ROWS*CELL_W;
  typedef struct {int kind; int data;} ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ev_t q[$];
  int errors = 0, checks = 0, cyc = 0;
  bit done_seen = 1'b0;
  logic [BW-1:0] model = '0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  board_if #(.COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W)) bus ();
  board_ctrl #(.COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_board(string name);
    bit shown = 0;
    checks++;
    if (bus.o_board !== model) begin
      errors++;
      for (int k = 0; k < ROWS*COLS; k++)
        if (!shown && bus.o_board[k*CELL_W +: CELL_W] !== model[k*CELL_W +: CELL_W]) begin
          shown = 1;
          $display("FAIL %s: cell(%0d,%0d) got %0d expected %0d", name, k / COLS, k % COLS,
                   bus.o_board[k*CELL_W +: CELL_W], model[k*CELL_W +: CELL_W]);
        end
    end
  endtask
  task automatic expect_ev(int kind, int data);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d data %0h expected none", kind, data);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.data != data) begin
        errors++;
        $display("FAIL event: got kind %0d data %0h expected kind %0d data %0h",
                 kind, data, e.kind, e.data);
      end
    end
  endtask
  // kind 0 = grant ({ready1,ready0}), 1 = write error, 2 = scan done ({lines, cycle})
  always @(negedge clk) if (rst_n) begin
    if (bus.o_req0_ready || bus.o_req1_ready)
      expect_ev(0, int'({bus.o_req1_ready, bus.o_req0_ready}));
    if (bus.o_wr_err) expect_ev(1, 0);
    if (bus.o_clr_done) begin
      done_seen = 1'b1;
      expect_ev(2, (int'(bus.o_clr_lines) << 16) | (cyc & 16'hffff));
    end
  end
  task automatic push(int k, int d);
    ev_t e;
    e.kind = k;
    e.data = d;
    q.push_back(e);
  endtask
  task automatic set_model(int r, int c, int v);
    model[(r*COLS+c)*CELL_W +: CELL_W] = CELL_W'(v);
  endtask
  task automatic wr(int req, int r, int c, int v);
    bit bad = (r >= ROWS || c >= COLS);
    if (req == 0) begin
      bus.i_req0_valid = 1; bus.i_req0_row = 5'(r); bus.i_req0_col = 4'(c); bus.i_req0_cell = CELL_W'(v);
    end else begin
      bus.i_req1_valid = 1; bus.i_req1_row = 5'(r); bus.i_req1_col = 4'(c); bus.i_req1_cell = CELL_W'(v);
    end
    push(0, req == 0 ? 1 : 2);
    if (bad) push(1, 0);
    else set_model(r, c, v);
    @(posedge clk); #1;
    bus.i_req0_valid = 0;
    bus.i_req1_valid = 0;
    if (bad) begin @(posedge clk); #1; end
  endtask
  task automatic fill();
    for (int c = 0; c < COLS; c++) wr(0, 19, c, c + 1);
    for (int c = 0; c < COLS; c++) wr(0, 18, c, 3);
    wr(0, 17, 4, 5);
  endtask
  task automatic run_clear(string name, int stall_at, int exp_lines, int exp_len);
    int s = cyc;
    done_seen = 0;
    bus.i_clr_start = 1;
    push(2, (exp_lines << 16) | ((s + exp_len) & 16'hffff));
    @(posedge clk); #1;
    bus.i_clr_start = 0;
    chk({name, "_busy_start"}, int'(bus.o_clr_busy), 1);
    for (int i = 0; i < 200 && !done_seen; i++) begin
      bus.i_clr_start = (cyc == s + 5);
      bus.i_sync_va = stall_at > 0 && cyc >= s + stall_at && cyc < s + stall_at + 3;
      @(posedge clk); #1;
    end
    bus.i_clr_start = 0;
    bus.i_sync_va = 0;
    chk({name, "_done_seen"}, int'(done_seen), 1);
    chk({name, "_busy_end"}, int'(bus.o_clr_busy), 0);
    chk({name, "_lines"}, int'(bus.o_clr_lines), exp_lines);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int s;
    int exp_g[4];
    bus.i_sync_va = 0; bus.i_clr_start = 0; bus.i_rd_row = 0; bus.i_rd_col = 0;
    bus.i_req0_valid = 1; bus.i_req0_row = 0; bus.i_req0_col = 0; bus.i_req0_cell = 7;
    bus.i_req1_valid = 1; bus.i_req1_row = 0; bus.i_req1_col = 1; bus.i_req1_cell = 7;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", int'(bus.o_req0_ready), 0);
    chk("rst_ready1", int'(bus.o_req1_ready), 0);
    chk("rst_busy", int'(bus.o_clr_busy), 0);
    chk("rst_done", int'(bus.o_clr_done), 0);
    chk("rst_lines", int'(bus.o_clr_lines), 0);
    chk("rst_wr_err", int'(bus.o_wr_err), 0);
    chk_board("rst_board");
    bus.i_req0_valid = 0; bus.i_req1_valid = 0;
    rst_n = 1;
    @(posedge clk); #1;
    // Tie between both requesters for four cycles.
    bus.i_req0_valid = 1; bus.i_req0_row = 0; bus.i_req0_col = 0; bus.i_req0_cell = 1;
    bus.i_req1_valid = 1; bus.i_req1_row = 0; bus.i_req1_col = 1; bus.i_req1_cell = 2;
`ifdef BOARD_CTRL_RR_EN
    exp_g = '{1, 2, 1, 2};
    set_model(0, 1, 2);
`else
    exp_g = '{1, 1, 1, 1};
`endif
    set_model(0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      push(0, exp_g[i]);
      @(posedge clk); #1;
    end
    bus.i_req0_valid = 0; bus.i_req1_valid = 0;
    chk_board("tie_board");
    bus.i_rd_row = 0; bus.i_rd_col = 0; #1;
    chk("tie_rd00", int'(bus.o_rd_cell), 1);
    bus.i_rd_col = 1; #1;
`ifdef BOARD_CTRL_RR_EN
    chk("tie_rd01", int'(bus.o_rd_cell), 2);
`else
    chk("tie_rd01", int'(bus.o_rd_cell), 0);
`endif
    // Active video blocks the write until blanking.
    bus.i_sync_va = 1;
    bus.i_req0_valid = 1; bus.i_req0_row = 2; bus.i_req0_col = 3; bus.i_req0_cell = 9;
    #1;
    chk("va_ready0", int'(bus.o_req0_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    chk_board("va_board_held");
    bus.i_sync_va = 0;
    push(0, 1);
    set_model(2, 3, 9);
    #1;
    chk("va_drop_ready0", int'(bus.o_req0_ready), 1);
    @(posedge clk); #1;
    bus.i_req0_valid = 0;
    bus.i_rd_row = 2; bus.i_rd_col = 3; #1;
    chk("va_rd23", int'(bus.o_rd_cell), 9);
    wr(1, 25, 3, 4);
    chk_board("oor_board");
    bus.i_rd_row = 25; bus.i_rd_col = 3; #1;
    chk("oor_rd", int'(bus.o_rd_cell), 0);
    // Line clear: two full bottom rows, one lone cell above them.
    wr(0, 0, 0, 0);
    wr(0, 0, 1, 0);
    wr(0, 2, 3, 0);
    fill();
    run_clear("clr", 0, 2, ROWS + 4 + 1);
    model = '0;
    set_model(19, 4, 5);
    chk_board("clr_board");
    bus.i_rd_row = 19; bus.i_rd_col = 4; #1;
    chk("clr_rd194", int'(bus.o_rd_cell), 5);
    fill();
    run_clear("stall", 10, 2, ROWS + 4 + 1 + 3);
    model = '0;
    set_model(19, 4, 5);
    chk_board("stall_board");
    // Start during active video is held pending until blanking.
    s = cyc;
    done_seen = 0;
    bus.i_sync_va = 1;
    bus.i_clr_start = 1;
    push(2, (0 << 16) | ((s + ROWS + 2) & 16'hffff));
    @(posedge clk); #1;
    bus.i_clr_start = 0;
    chk("pend_busy_held", int'(bus.o_clr_busy), 0);
    bus.i_sync_va = 0;
    for (int i = 0; i < 200 && !done_seen; i++) begin
      @(posedge clk); #1;
    end
    chk("pend_done_seen", int'(done_seen), 1);
    chk("pend_lines", int'(bus.o_clr_lines), 0);
    chk_board("pend_board");
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/board_ctrl.md
# board_ctrl

Owner of the play-field cell store shown by the DVI overlay renderer. Arbitrates cell writes from two game-logic requesters and runs a line-clear engine that removes full rows and drops everything above. The board is modified only during vertical blanking, so the renderer never sees a torn frame. It exposes both a flat board vector and a single-cell read port to the renderer.

## Interface
Parameters:
- COLS, 10, columns (cell x index 0..COLS-1)
- ROWS, 20, rows (row 0 = top)
- CELL_W, 4, bits per cell; 0 = empty, nonzero = occupied colour code

Ports:
- clk  in  1  pixel clock, single clock domain
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- i_sync_va  in  1  vertical active; board may change only while 0
- i_req0_valid  in  1  requester 0 write request
- i_req0_row  in  5  target row
- i_req0_col  in  4  target column
- i_req0_cell  in  CELL_W  value to write
- o_req0_ready  out  1  combinational grant; write takes effect at this edge
- i_req1_valid / i_req1_row / i_req1_col / i_req1_cell / o_req1_ready: same as requester 0
- i_clr_start  in  1  one-cycle pulse: run line-clear scan
- o_clr_busy  out  1  line-clear in progress
- o_clr_done  out  1  one-cycle pulse at scan completion
- o_clr_lines  out  5  rows removed by last completed scan
- o_wr_err  out  1  one-cycle pulse: granted write had row>=ROWS or col>=COLS (dropped)
- i_rd_row  in  5  renderer read row
- i_rd_col  in  4  renderer read column
- o_rd_cell  out  CELL_W  combinational cell at (i_rd_row,i_rd_col); 0 if out of range
- o_board  out  COLS*ROWS*CELL_W  flat board; cell (r,c) at bits [(r*COLS+c)*CELL_W +: CELL_W]

## Operation
- Reset (rst_n=0 at an edge): all cells 0, state IDLE, o_clr_busy=0, o_clr_done=0, o_clr_lines=0, o_wr_err=0, round-robin pointer = requester 0. Reset overrides everything, including a scan in progress.
- States: IDLE, SCAN, SHIFT, DONE.
- IDLE, i_sync_va=1: no readies, no changes; i_clr_start is latched as pending.
- IDLE, i_sync_va=0: if i_clr_start or pending-start, go to SCAN with row index r=ROWS-1, no write granted this cycle. Otherwise grant at most one valid requester. If both are valid, the pointer chooses, and after a grant it points to the other requester. The granted ready is 1, the cell is written at the edge, and o_wr_err pulses next cycle if out of range (the write is dropped).
- SCAN: if all COLS cells of row r are nonzero, go to SHIFT. Otherwise, if r==0, go to DONE; else r<=r-1.
- SHIFT: rows r..1 take rows r-1..0; row 0 is cleared; o_clr_lines+1 (saturates at 31); return to SCAN at the same r.
- DONE: o_clr_done=1 for this cycle, o_clr_busy drops, go to IDLE.
- o_clr_lines resets to 0 on entry to SCAN and holds its value after DONE until the next scan.
- Any state other than IDLE with i_sync_va=1 stalls: the state, r and the board are held.
- i_clr_start while busy is ignored.
- Readies are always 0 outside IDLE.

## Timing
- Write: registered; the cell is visible on o_board / o_rd_cell the cycle after the grant edge.
- o_rd_cell: zero-latency combinational from o_board.
- Line-clear latency, start sampled at cycle 0 with no stalls and k full rows: SCAN/SHIFT occupy cycles 1..ROWS+2k, and o_clr_done is high in cycle ROWS+2k+1.
- o_clr_busy is high from cycle 1 through cycle ROWS+2k.
- Stall cycles add one-for-one.

## Configuration
- BOARD_CTRL_RR_EN defined: round-robin arbitration as described.
- BOARD_CTRL_RR_EN undefined: fixed priority. Requester 0 always wins a tie and the pointer logic is removed.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with valid writes pending -> every cell 0, all outputs 0, no readies.
- Tie arbitration (RR_EN), va=0: both requesters valid for 4 cycles writing (0,0)=1 and (0,1)=2 -> grants ordered req0, req1, req0, req1; cells read back 1 and 2.
- Blanking gate: i_sync_va=1 with req0 valid -> ready=0 and board unchanged. Drop va to 0 -> grant in the same cycle.
- Out of range: req1 writes row 25, col 3 -> ready=1, o_wr_err pulses the next cycle, o_board unchanged.
- Line clear: rows 19 and 18 full, (17,4)=5, start pulse -> o_clr_done at cycle 25, o_clr_lines=2, cell (19,4)=5, rows 0..18 all 0.
- Stall: assert i_sync_va for 3 cycles mid-scan -> o_clr_done is delayed by exactly 3 cycles and the result is identical.
